// File: rtl/sort4_ctrl.sv
// Four-entry ascending sorter: one shared unsigned comparator, bubble schedule with early exit.
// Optional SORT4_SWAP_COUNT_EN adds swap_count (swaps made by the most recent sort).
module sort4_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       load_idx,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [1:0]       out_idx,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
`ifdef SORT4_SWAP_COUNT_EN
  ,
  output logic [3:0]       swap_count
`endif
);

  localparam int unsigned N = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SORT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] arr_q [N];
  logic [1:0]       pass_q;
  logic [1:0]       j_q;
  logic             swapped_q;

  logic [1:0] j_nxt_c;
  logic       gt_c;

  // Shared comparator always looks at the current adjacent pair.
  assign j_nxt_c  = j_q + 2'd1;
  assign gt_c     = arr_q[j_q] > arr_q[j_nxt_c];
  assign out_data = arr_q[out_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_q    <= 2'd0;
      j_q       <= 2'd0;
      swapped_q <= 1'b0;
      for (int i = 0; i < N; i++) arr_q[i] <= '0;
    end else begin
      case (state_q)
        S_SORT: begin
          if (gt_c) begin
            arr_q[j_q]     <= arr_q[j_nxt_c];
            arr_q[j_nxt_c] <= arr_q[j_q];
          end
          if (j_q == 2'd2) begin
            // Pass ends: stop when nothing moved this pass or the last pass is done.
            if (!(swapped_q || gt_c) || (pass_q == 2'd2)) begin
              state_q <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              pass_q    <= pass_q + 2'd1;
              j_q       <= 2'd0;
              swapped_q <= 1'b0;
            end
          end else begin
            j_q       <= j_nxt_c;
            swapped_q <= swapped_q | gt_c;
          end
        end
        default: begin
          done <= 1'b0;
          if (load) arr_q[load_idx] <= load_data;
          if (start) begin
            state_q   <= S_SORT;
            busy      <= 1'b1;
            pass_q    <= 2'd0;
            j_q       <= 2'd0;
            swapped_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef SORT4_SWAP_COUNT_EN
  logic start_acc_c;
  logic swap_c;

  assign start_acc_c = (state_q != S_SORT) && start;
  assign swap_c      = (state_q == S_SORT) && gt_c;

  always_ff @(posedge clk) begin
    if (rst || start_acc_c) begin
      swap_count <= 4'd0;
    end else if (swap_c) begin
      swap_count <= swap_count + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sort4_ctrl.sv
// Bench for sort4_ctrl: protocol-level reference model, per-cycle compare, directed and random stimulus.
module tb_sort4_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [1:0]   load_idx;
  logic [W-1:0] load_data;
  logic         start;
  logic [1:0]   out_idx;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;
`ifdef SORT4_SWAP_COUNT_EN
  logic [3:0]   swap_count;
`endif

  sort4_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_idx  (load_idx),
    .load_data (load_data),
    .start     (start),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
`ifdef SORT4_SWAP_COUNT_EN
    ,
    .swap_count(swap_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
  endtask

  // Reference model: contents, remaining busy cycles, done pulse, swap total.
  int m_arr [4];
  int m_left  = 0;
  int m_cnt   = 0;
  bit m_done  = 1'b0;
  bit m_valid = 1'b0;

  function automatic int n_passes();
    int a [4];
    int p;
    bit moved;
    int t;
    a = m_arr;
    p = 0;
    do begin
      moved = 1'b0;
      for (int j = 0; j < 3; j++) begin
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          moved = 1'b1;
        end
      end
      p++;
    end while (moved && p < 3);
    return p;
  endfunction

  function automatic int inversions();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (m_arr[i] > m_arr[j]) n++;
    return n;
  endfunction

  // Stable rank placement gives the expected final order.
  function automatic void sort_model();
    int res [4];
    int r;
    for (int i = 0; i < 4; i++) begin
      r = 0;
      for (int j = 0; j < 4; j++)
        if (m_arr[j] < m_arr[i] || (m_arr[j] == m_arr[i] && j < i)) r++;
      res[r] = m_arr[i];
    end
    m_arr = res;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_arr[i] = 0;
      m_left  = 0;
      m_done  = 1'b0;
      m_cnt   = 0;
      m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (load) m_arr[load_idx] = int'(load_data);
      if (start) begin
        m_left = 3 * n_passes();
        m_cnt  = inversions();
        sort_model();
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", int'(busy), int'(m_left > 0));
      chk("done", int'(done), int'(m_done));
      if (m_left == 0) begin
        chk("out_data", int'(out_data), m_arr[out_idx]);
`ifdef SORT4_SWAP_COUNT_EN
        chk("swap_count", int'(swap_count), m_cnt);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    int v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; load_idx = 2'(i); load_data = W'(v[i]);
      tick();
    end
    load = 1'b0;
  endtask

  task automatic read_chk(input int idx, input int exp);
    out_idx = 2'(idx);
    @(negedge clk);
    chk($sformatf("read[%0d]", idx), int'(out_data), exp);
    tick();
  endtask

  task automatic read4(input int a, input int b, input int c, input int d);
    read_chk(0, a); read_chk(1, b); read_chk(2, c); read_chk(3, d);
  endtask

  task automatic chk_sc(input int exp);
`ifdef SORT4_SWAP_COUNT_EN
    chk("swap_count_lit", int'(swap_count), exp);
`else
    if (exp < 0) $display("swap count unavailable");
`endif
  endtask

  // Start a sort (optionally with a same-cycle load of idx0), count busy cycles until done.
  task automatic run_sort(input int exp_k, input bit poke, input bit ld0, input int ld0_val);
    int cnt;
    bit got;
    start = 1'b1;
    if (ld0) begin load = 1'b1; load_idx = 2'd0; load_data = W'(ld0_val); end
    tick();
    start = 1'b0; load = 1'b0;
    cnt = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (busy) cnt++;
        tick();
        load = 1'b0; start = 1'b0;
        if (poke && cnt == 2) begin
          load = 1'b1; load_idx = 2'd0; load_data = W'(3); start = 1'b1;
        end
      end
    end
    chk("done_seen", int'(got), 1);
    chk("busy_cycles", cnt, exp_k);
    tick();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0;
    load_idx = '0; load_data = '0; out_idx = '0;
    tick();
    rst = 1'b0;
    load4(11, 6, 13, 2);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    tick();
    read4(0, 0, 0, 0);

    load4(1, 2, 3, 4);
    run_sort(3, 1'b0, 1'b0, 0);
    read4(1, 2, 3, 4);
    chk_sc(0);

    load4(9, 7, 4, 0);
    run_sort(9, 1'b0, 1'b0, 0);
    read4(0, 4, 7, 9);
    chk_sc(6);

    load4(15, 5, 0, 5);
    run_sort(9, 1'b0, 1'b0, 0);
    read4(0, 5, 5, 15);
    chk_sc(4);

    load4(4, 3, 2, 1);
    run_sort(9, 1'b1, 1'b0, 0);
    read4(1, 2, 3, 4);

    load4(5, 6, 7, 8);
    run_sort(6, 1'b0, 1'b1, 10);
    read4(6, 7, 8, 10);
    chk_sc(3);

    // Reset during busy cycle 4.
    load4(9, 7, 4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      tick();
    end
    read4(0, 0, 0, 0);
    load4(2, 1, 0, 3);
    run_sort(9, 1'b0, 1'b0, 0);
    read4(0, 1, 2, 3);
    chk_sc(3);

    // Random traffic, including extremes and commands during SORT/DONE.
    repeat (800) begin
      int r;
      load     = 1'($urandom % 2);
      load_idx = 2'($urandom);
      r = int'($urandom % 4);
      load_data = (r == 0) ? W'(0) : (r == 1) ? W'((1 << W) - 1) : W'($urandom);
      start   = ($urandom % 5) == 0;
      out_idx = 2'($urandom);
      tick();
    end
    load = 1'b0; start = 1'b0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sort4_ctrl.md
Name: sort4_ctrl

Overview:
- Sequencing controller that sorts a 4-entry register array of unsigned WIDTH-bit values in ascending order.
- Uses a single shared magnitude comparator, one compare per cycle, in a bubble-sort schedule with early exit.
- Sits between a host that loads and reads the array and the comparator datapath; it owns the array storage and the compare/swap schedule.

Parameters:
- WIDTH, 4, bit width of each element; unsigned compare.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  write load_data into array[load_idx]; honoured only when not busy
- load_idx  input  2  element index for load
- load_data  input  WIDTH  element value for load
- start  input  1  begin a sort; honoured only in IDLE or DONE
- out_idx  input  2  read index
- out_data  output  WIDTH  combinational array[out_idx]; valid in every state
- busy  output  1  high while the sort is in progress
- done  output  1  one-cycle pulse when the sort completes

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; array[0..3]=0; busy=0; done=0; pass=0; j=0; swap flag=0. Reset overrides all other inputs, including mid-sort; the partial result is discarded.
- States are IDLE, SORT and DONE.
- IDLE:
  - load=1 writes array[load_idx].
  - start=1 moves to SORT with pass=0, j=0, swap flag=0.
  - load and start in the same cycle: the write is applied, and the sort uses the updated array.
- SORT (busy=1), one comparison per cycle:
  - Compare array[j] against array[j+1], unsigned.
  - If greater, swap the two entries at this edge and set the swap flag. Equal or lesser means no swap, so the sort is stable.
  - j steps 0 -> 1 -> 2. When j=2, the pass ends:
    - If the swap flag is 0 (including the swap decision of this cycle), or pass=2, go to DONE.
    - Otherwise pass++, j=0, swap flag cleared.
  - load and start are ignored in SORT.
- DONE:
  - Lasts exactly one cycle with done=1 and busy=0, then returns to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE.
  - load=1 in DONE is honoured.
- Latency: start sampled at edge T gives busy=1 for cycles T+1..T+k and done=1 in cycle T+k+1.
  - k = 3 x (number of passes executed), so k is 3, 6 or 9.
  - Already sorted input: k=3. Worst case: k=9.
- out_data during SORT shows in-progress contents. After done, array[0] <= array[1] <= array[2] <= array[3].
- Width rule: the compare is pure unsigned magnitude across all WIDTH bits; there is no sign interpretation. Values 0 and 2^WIDTH-1 must order correctly.
- The swap flag is internal; the comparator is used only in SORT.

Optional Feature:
- Macro: SORT4_SWAP_COUNT_EN.
- When defined:
  - Adds output swap_count (4 bits): number of swaps performed by the most recent sort, range 0..6.
  - Cleared to 0 on reset and at start acceptance.
  - Increments on each swap edge; holds its value after done until the next start.
- When undefined: no swap_count port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: hold rst for 2 cycles after arbitrary loads -> out_data=0 for idx 0..3, busy=0, done=0.
- Sorted input: load {1,2,3,4}, start at T -> busy in T+1..T+3, done at T+4, array {1,2,3,4}, swap_count=0.
- Reverse input: load {9,7,4,0}, start -> 9 busy cycles, done at T+10, array {0,4,7,9}, swap_count=6.
- Duplicates and extremes: load {15,5,0,5}, start -> array {0,5,5,15}; equal pairs never swap; 15 ordered above 0.
- Protocol: during SORT, pulse load idx0=3 and start -> both ignored, result unchanged; load+start in the same IDLE cycle -> the sort uses the new value.
- Reset mid-sort: assert rst at busy cycle 4 -> next cycle IDLE, array all 0, no done pulse; a following start on {2,1,0,3} completes correctly.
